misr_bist_ctrl: RTL and testbench

//  Parametrised MISR/LFSR signature block with run control, replacing the fixed 8-bit MISR.

---
 rtl/misr_bist_ctrl_pkg.sv | 29 ++
 rtl/misr_bist_ctrl_if.sv | 31 +++
 rtl/misr_bist_ctrl_next.sv | 25 ++
 rtl/misr_bist_ctrl.sv | 103 ++++++++++
 tb/tb_misr_bist_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/misr_bist_ctrl_pkg.sv
// Shared types and default constants for the MISR/LFSR signature block.
// Default feedback taps are Galois taps with the x^WIDTH term implicit.
package misr_bist_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [31:0] DEF_SEED = 32'h0000_0001;

    function automatic logic [31:0] default_poly(input int w);
        logic [31:0] p;
        case (w)
            4:       p = 32'h0000_0003;
            5:       p = 32'h0000_0005;
            6:       p = 32'h0000_0003;
            7:       p = 32'h0000_0003;
            8:       p = 32'h0000_001D;
            16:      p = 32'h0000_100B;
            24:      p = 32'h0000_001B;
            32:      p = 32'h04C1_1DB7;
            default: p = 32'h0000_001D;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/misr_bist_ctrl_if.sv
// Run-control and result bundle between the BIST sequencer and the signature block.
// The sequencer side is the master; the signature block is the slave.
interface misr_bist_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 1,
    parameter int CNT_W = 16
);

    logic             start;
    logic             mode;
    logic [CNT_W-1:0] n_cycles;
    logic             grant_o;
    logic [N_IN-1:0]  scan_in;
    logic [WIDTH-1:0] golden;
    logic [WIDTH-1:0] signature;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] period;

    modport master (
        output start, mode, n_cycles, grant_o, scan_in, golden,
        input  signature, busy, done, pass, period
    );

    modport slave (
        input  start, mode, n_cycles, grant_o, scan_in, golden,
        output signature, busy, done, pass, period
    );

endinterface

// File: rtl/misr_bist_ctrl_next.sv
// Combinational next-signature function: Galois shift with feedback taps,
// plus the zero-extended scan inputs folded in when compacting.
module misr_bist_ctrl_next #(
    parameter int             WIDTH = 8,
    parameter int             N_IN  = 1,
    parameter logic [WIDTH-1:0] POLY = 8'h1D
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [N_IN-1:0]  scan_in,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] scan_ext;
    logic [WIDTH-1:0] fb;

    always_comb begin
        scan_ext = '0;
        if (!mode) scan_ext[N_IN-1:0] = scan_in;
    end

    assign fb  = sig[WIDTH-1] ? POLY : '0;
    assign nxt = {sig[WIDTH-2:0], 1'b0} ^ fb ^ scan_ext;

endmodule

// File: rtl/misr_bist_ctrl.sv
// MISR/LFSR signature block with run control, golden compare and
// LFSR period measurement.
module misr_bist_ctrl
    import misr_bist_ctrl_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               N_IN  = 1,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter int               CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    misr_bist_ctrl_if.slave    bus
);

    state_t           state;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] n_q;
    logic             mode_q;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [CNT_W-1:0] period_r;
    logic             seed_hit;
    logic             last;

    misr_bist_ctrl_next #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .POLY  (POLY)
    ) u_next (
        .sig     (sig),
        .scan_in (bus.scan_in),
        .mode    (mode_q),
        .nxt     (nxt)
    );

    assign cnt_inc  = cnt + CNT_W'(1);
    assign seed_hit = mode_q && (nxt == SEED);
    assign last     = (cnt_inc == n_q) || seed_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sig      <= SEED;
            cnt      <= '0;
            n_q      <= '0;
            mode_q   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            period_r <= '0;
        end else if (bus.start) begin
            // A start from any state discards whatever run was in flight.
            sig      <= SEED;
            cnt      <= '0;
            period_r <= '0;
            n_q      <= bus.n_cycles;
            mode_q   <= bus.mode;
            if (bus.n_cycles == '0) begin
                state  <= ST_DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
                pass_r <= (SEED == bus.golden);
            end else begin
                state  <= ST_RUN;
                busy_r <= 1'b1;
                done_r <= 1'b0;
                pass_r <= 1'b0;
            end
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (bus.grant_o) begin
                        sig <= nxt;
                        cnt <= cnt_inc;
                        if (last) begin
                            state  <= ST_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (nxt == bus.golden);
                            if (seed_hit) period_r <= cnt_inc;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.signature = sig;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.period    = period_r;

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Directed vector bench for misr_bist_ctrl (WIDTH=8, N_IN=1, POLY=0x1D, SEED=0x01).
module tb_misr_bist_ctrl;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    misr_bist_ctrl_if #(.WIDTH(8), .N_IN(1), .CNT_W(16)) bus ();

    misr_bist_ctrl #(.WIDTH(8), .N_IN(1), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        int         n;
        logic       scan;
        logic [7:0] golden;
        logic [7:0] sig;
        logic       pass;
        int         period;
        int         steps;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input int n, input logic [7:0] g);
        bus.mode     = m;
        bus.n_cycles = 16'(n);
        bus.golden   = g;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int steps;
        bus.scan_in = vecs[k].scan;
        bus.grant_o = 1'b1;
        do_start(vecs[k].mode, vecs[k].n, vecs[k].golden);
        if (vecs[k].n != 0) check($sformatf("v%0d_busy", k), 32'(bus.busy), 32'd1);
        steps = 0;
        while (!bus.done && steps < 400) begin
            tick();
            steps++;
        end
        check($sformatf("v%0d_steps", k), 32'(steps), 32'(vecs[k].steps));
        check($sformatf("v%0d_sig", k), 32'(bus.signature), 32'(vecs[k].sig));
        check($sformatf("v%0d_pass", k), 32'(bus.pass), 32'(vecs[k].pass));
        check($sformatf("v%0d_period", k), 32'(bus.period), 32'(vecs[k].period));
        check($sformatf("v%0d_idle", k), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] seq[8];

        n_cmp = 0;
        n_err = 0;

        //         mode n    scan golden  sig    pass per  steps
        vecs[0] = '{1'b0, 1,   1'b1, 8'h03, 8'h03, 1'b1, 0,   1};
        vecs[1] = '{1'b0, 8,   1'b0, 8'h1D, 8'h1D, 1'b1, 0,   8};
        vecs[2] = '{1'b1, 300, 1'b0, 8'h01, 8'h01, 1'b1, 255, 255};
        vecs[3] = '{1'b1, 10,  1'b1, 8'h00, 8'h74, 1'b0, 0,   10};
        vecs[4] = '{1'b0, 3,   1'b1, 8'h0F, 8'h0F, 1'b1, 0,   3};
        vecs[5] = '{1'b0, 0,   1'b1, 8'h01, 8'h01, 1'b1, 0,   0};
        vecs[6] = '{1'b0, 2,   1'b1, 8'h55, 8'h07, 1'b0, 0,   2};
        vecs[7] = '{1'b0, 9,   1'b0, 8'h3A, 8'h3A, 1'b1, 0,   9};

        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.n_cycles = '0;
        bus.grant_o  = 1'b0;
        bus.scan_in  = '0;
        bus.golden   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_sig", 32'(bus.signature), 32'h01);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_period", 32'(bus.period), 32'd0);

        // grant and scan have no effect while idle
        bus.grant_o = 1'b1;
        bus.scan_in = 1'b1;
        tick();
        tick();
        check("idle_hold", 32'(bus.signature), 32'h01);

        for (int k = 0; k < 8; k++) run_vec(k);

        // step-by-step shift sequence
        bus.scan_in = 1'b0;
        bus.grant_o = 1'b1;
        do_start(1'b0, 8, 8'h1D);
        check("seq_seed", 32'(bus.signature), 32'h01);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("seq_%0d", i), 32'(bus.signature), 32'(seq[i]));
            check($sformatf("seq_done_%0d", i), 32'(bus.done), (i == 7) ? 32'd1 : 32'd0);
        end

        // grant low on alternate cycles
        bus.grant_o = 1'b0;
        do_start(1'b0, 8, 8'h1D);
        for (int c = 1; c <= 16; c++) begin
            bus.grant_o = (c % 2 == 0);
            tick();
            if (c == 15) check("alt_not_done", 32'(bus.done), 32'd0);
        end
        check("alt_done", 32'(bus.done), 32'd1);
        check("alt_sig", 32'(bus.signature), 32'h1D);
        check("alt_pass", 32'(bus.pass), 32'd1);

        // restart mid-run, then rst together with start
        bus.grant_o = 1'b1;
        bus.scan_in = 1'b1;
        do_start(1'b0, 100, 8'h00);
        tick();
        tick();
        tick();
        check("mid_sig", 32'(bus.signature), 32'h0F);
        do_start(1'b0, 2, 8'h00);
        check("restart_sig", 32'(bus.signature), 32'h01);
        check("restart_busy", 32'(bus.busy), 32'd1);
        tick();
        check("restart_step", 32'(bus.signature), 32'h03);
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rstwin_sig", 32'(bus.signature), 32'h01);
        check("rstwin_busy", 32'(bus.busy), 32'd0);
        check("rstwin_done", 32'(bus.done), 32'd0);
        tick();
        check("rstwin_idle", 32'(bus.signature), 32'h01);
        do_start(1'b0, 0, 8'h01);
        check("zero_done", 32'(bus.done), 32'd1);
        check("zero_sig", 32'(bus.signature), 32'h01);
        check("zero_pass", 32'(bus.pass), 32'd1);
        check("zero_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
